// File: rtl/iram_fetch_arbiter.sv
// Round-robin arbiter sharing one single-port instruction RAM between NUM_CORES fetch units.
// Each fetch takes three cycles: grant/address, RAM access, data return with rvalid pulse.
module iram_fetch_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic [ADDR_W-1:0]             iram_addr,
  input  logic [DATA_W-1:0]             iram_data
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     ptr_q;

  logic [ADDR_W-1:0]   addr_arr [NUM_CORES];
  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     win_next;
  logic [IdxW-1:0]     cand;
  logic [NUM_CORES-1:0] win_onehot;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_addr
    assign addr_arr[k] = addr[k*ADDR_W +: ADDR_W];
  end

  // First requester at or above ptr_q, wrapping modulo NUM_CORES.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NUM_CORES);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_next   = (win_idx == IdxW'(NUM_CORES - 1)) ? '0 : win_idx + IdxW'(1);
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      iram_addr <= '0;
    end else begin
      rvalid <= '0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            iram_addr <= addr_arr[win_idx];
            gnt       <= win_onehot;
            busy      <= 1'b1;
            ptr_q     <= win_next;
            state_q   <= StAddr;
          end
        end
        StAddr: state_q <= StData;
        StData: begin
          // gnt still holds the owner's one-hot code here.
          rdata   <= iram_data;
          rvalid  <= gnt;
          gnt     <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Bench for iram_fetch_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-level reference model and a behavioural IRAM.
module tb_iram_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] iram_addr;
  logic [DW-1:0] iram_data;

  iram_fetch_arbiter #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .iram_addr (iram_addr),
    .iram_data (iram_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [16];
  always @(posedge clk) iram_data <= ram[iram_addr[3:0]];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a fetch occupies the arbiter for three edges.
  int            m_ptr;
  int            m_left;
  int            m_own;
  logic [N-1:0]  m_gnt;
  logic [N-1:0]  m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          m_busy;
  logic [AW-1:0] m_iaddr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit found;
    if (rst) begin
      m_ptr = 0; m_left = 0; m_own = 0;
      m_gnt = '0; m_rvalid = '0; m_rdata = '0; m_busy = 1'b0; m_iaddr = '0;
    end else begin
      m_rvalid = '0;
      if (m_left == 0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (!found && req[c]) begin
            found    = 1;
            m_own    = c;
            m_gnt    = '0;
            m_gnt[c] = 1'b1;
            m_busy   = 1'b1;
            m_iaddr  = addr[c*AW +: AW];
            m_ptr    = (c + 1) % N;
            m_left   = 2;
          end
        end
      end else if (m_left == 2) begin
        m_left = 1;
      end else begin
        m_rdata         = ram[m_iaddr[3:0]];
        m_rvalid        = '0;
        m_rvalid[m_own] = 1'b1;
        m_gnt           = '0;
        m_busy          = 1'b0;
        m_left          = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("gnt",       gnt,       m_gnt);
    check_eq("rvalid",    rvalid,    m_rvalid);
    check_eq("rdata",     rdata,     m_rdata);
    check_eq("busy",      busy,      m_busy);
    check_eq("iram_addr", iram_addr, m_iaddr);
  endtask

  int lat;
  int nrv;
  logic [N-1:0]  rv_core [$];
  logic [DW-1:0] rv_data [$];
  logic [N-1:0]  exp_core [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [DW-1:0] exp_data [4] = '{16'd35, 16'd7, 16'd5, 16'd35};
  int            exp_cyc  [4] = '{3, 6, 9, 12};
  int            rv_cyc [$];

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = DW'($urandom);
    ram[0] = 16'd35; ram[1] = 16'd7; ram[3] = 16'd5;
    rst = 1'b1; req = '0; addr = '0;
    step(); step();
    rst = 1'b0;

    // Single request from core 2.
    addr[2*AW +: AW] = 16'd3;
    req = 4'b0100;
    lat = -1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (rvalid[2] && lat < 0) lat = c;
      req &= ~rvalid;
    end
    check_eq("t1_latency", lat, 3);
    check_eq("t1_rdata", rdata, 16'd5);

    // All cores at once from reset pointer.
    rst = 1'b1; step(); rst = 1'b0;
    addr = {16'd0, 16'd3, 16'd1, 16'd0};
    req  = '1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (rvalid != '0) begin
        rv_core.push_back(rvalid); rv_data.push_back(rdata); rv_cyc.push_back(c);
      end
      req &= ~rvalid;
    end
    check_eq("t2_count", rv_core.size(), 4);
    for (int i = 0; i < 4 && i < rv_core.size(); i++) begin
      check_eq("t2_order", rv_core[i], exp_core[i]);
      check_eq("t2_data",  rv_data[i], exp_data[i]);
      check_eq("t2_cycle", rv_cyc[i],  exp_cyc[i]);
    end

    // Reset during DATA aborts the fetch; next request served normally.
    addr = '0;
    addr[1*AW +: AW] = 16'd1;
    req = 4'b0010;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("t6_rvalid_abort", rvalid, 4'b0000);
    nrv = 0; lat = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (rvalid[1]) begin nrv++; if (lat < 0) lat = c; end
      req &= ~rvalid;
    end
    check_eq("t6_count", nrv, 1);
    check_eq("t6_latency", lat, 3);
    check_eq("t6_rdata", rdata, 16'd7);

    // Random traffic obeying the request protocol, with rare resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < N; k++) begin
        if (rvalid[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          if (req[k]) addr[k*AW +: AW] = AW'($urandom);
        end else if (!req[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[k] = 1'b1;
            addr[k*AW +: AW] = AW'($urandom);
          end
        end else if (gnt[k]) begin
          if ($urandom_range(0, 3) == 0) addr[k*AW +: AW] = AW'($urandom);
          if ($urandom_range(0, 7) == 0) req[k] = 1'b0;
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
